// File: rtl/branch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_pc_unit
// Brief    : PC sequencing and taken-branch redirect with wrong-path flush
//            and a saturating taken-branch counter.
// Revision : 1.0 - initial release
// ============================================================================
module branch_pc_unit #(
    parameter int ADDR_W      = 32,
    parameter int PC_STEP     = 4,
    parameter int RESET_PC    = 0,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              brCond,
    input  logic [ADDR_W-1:0] brTarget,
    output logic [ADDR_W-1:0] pc,
    output logic              ifValid,
    output logic              flush,
    output logic              alignErr,
    output logic [15:0]       brTakenCnt
);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    localparam logic [ADDR_W-1:0] c_STEP       = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ADDR_W'(PC_STEP - 1);
    localparam logic [ADDR_W-1:0] c_RESET_PC   = ADDR_W'(RESET_PC);
    localparam logic [2:0]        c_FLUSH_INIT = 3'(FLUSH_DEPTH - 1);
    localparam logic [15:0]       c_CNT_MAX    = 16'hFFFF;

    logic [0:0]        r_state;
    logic [2:0]        r_flushCnt;
    logic [ADDR_W-1:0] r_pc;
    logic              r_ifValid;
    logic              r_flush;
    logic              r_alignErr;
    logic [15:0]       r_brTakenCnt;

    logic [ADDR_W-1:0] w_pcNext;
    logic [ADDR_W-1:0] w_targetAligned;
    logic              w_misaligned;

    // Sequential wrap past the top of the address space is intentional.
    assign w_pcNext        = r_pc + c_STEP;
    assign w_targetAligned = brTarget & ~c_ALIGN_MASK;
    assign w_misaligned    = |(brTarget & c_ALIGN_MASK);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RUN;
            r_flushCnt   <= 3'd0;
            r_pc         <= c_RESET_PC;
            r_ifValid    <= 1'b0;
            r_flush      <= 1'b0;
            r_alignErr   <= 1'b0;
            r_brTakenCnt <= 16'd0;
        end else begin
            r_alignErr <= 1'b0;
            if (r_state == S_RUN) begin
                // A taken branch redirects even while the pipeline is frozen.
                if (brCond) begin
                    r_pc       <= w_targetAligned;
                    r_alignErr <= w_misaligned;
                    r_flush    <= 1'b1;
                    r_ifValid  <= 1'b0;
                    r_flushCnt <= c_FLUSH_INIT;
                    r_state    <= S_FLUSH;
                    if (r_brTakenCnt != c_CNT_MAX) begin
                        r_brTakenCnt <= r_brTakenCnt + 16'd1;
                    end
                end else begin
                    r_flush   <= 1'b0;
                    r_ifValid <= 1'b1;
                    if (!freeze) begin
                        r_pc <= w_pcNext;
                    end
                end
            end else begin
                // brCond here belongs to a squashed instruction and is ignored.
                if (!freeze) begin
                    r_pc <= w_pcNext;
                    if (r_flushCnt == 3'd0) begin
                        r_state   <= S_RUN;
                        r_flush   <= 1'b0;
                        r_ifValid <= 1'b1;
                    end else begin
                        r_flushCnt <= r_flushCnt - 3'd1;
                    end
                end
            end
        end
    end

    assign pc         = r_pc;
    assign ifValid    = r_ifValid;
    assign flush      = r_flush;
    assign alignErr   = r_alignErr;
    assign brTakenCnt = r_brTakenCnt;

endmodule
`default_nettype wire
